nv_nvdla_mcif_read_ig_bpt_split: RTL and testbench
==================================================

Name: nv_nvdla_mcif_read_ig_bpt_split

Overview:
Sits directly downstream of the ingress BPT skid pipe stage and consumes its in_pd_p / in_vld_p / in_rdy_p handshake.
- Each DMA read request is a 64-bit address plus an atom count, with 32-byte atoms.
- The block splits each request into AXI-sized chunks so that no chunk crosses a 256-byte boundary.
- Chunks are emitted one per accepted output cycle toward the AXI request builder.

Parameters:
ADDR_W, 64, request address width.
SIZE_W, 15, atom-count field width; the field holds the number of atoms minus 1.
BOUND_ATOMS, 8, atoms per boundary window (256B / 32B); must be a power of 2.
LEN_W, 3, log2(BOUND_ATOMS); width of the chunk length field.

Ports:
nvdla_core_clk  in  1  clock
nvdla_core_rstn  in  1  reset
in_pd  in  79  request payload: {size[78:64], addr[63:0]}
in_vld  in  1  request valid
in_rdy  out  1  request ready
out_pd  out  69  chunk payload: {last[68], first[67], len[66:64] (atoms-1), addr[63:0]}
out_vld  out  1  chunk valid
out_rdy  in  1  chunk ready
split_idle  out  1  high when no request is held and the output register is empty

Behaviour:
- Reset: nvdla_core_rstn, asynchronous, active-low; clock nvdla_core_clk.
  - Reset values: out_vld=0, in_rdy=1, split_idle=1, state=IDLE; out_pd data is don't-care.
- Address handling:
  - in_pd addr[4:0] is ignored.
  - All out_pd addresses have addr[4:0]=0.
- State machine IDLE / SPLIT:
  - IDLE: in_rdy=1. An accepted request loads cur_addr and rem = size+1, where rem is SIZE_W+1 bits wide.
  - SPLIT: in_rdy=0.
- Chunk generation:
  - Chunk atoms n = min(rem, BOUND_ATOMS - cur_addr[7:5]).
  - Chunk fields: len = n-1; first=1 only for a request's first chunk; last=1 when n==rem.
  - Generation condition: out_load = !out_vld || out_rdy, and a chunk source must be present.
  - Chunk source is the accepted input (IDLE) or the held state (SPLIT).
  - On out_load with a chunk source: cur_addr += n*32 (modulo 2^64, wrap permitted) and rem -= n.
  - If last, the next state is IDLE; otherwise SPLIT.
- Latency and throughput:
  - A request accepted at cycle N presents its first chunk at N+1.
  - Each subsequent chunk follows one cycle after the previous one is consumed, giving back-to-back 1 chunk/cycle when out_rdy=1.
- Overlap: in IDLE, in_rdy stays 1 while the last chunk of the previous request is still registered, provided out_rdy=1 or out_vld=0. A new request therefore follows with no bubble.
- Output stability: out_pd and out_vld hold stable while out_vld && !out_rdy.
- Boundary cases:
  - size=0 gives one chunk with first=last=1.
  - A request already 256B-aligned with size=7 gives one chunk, len=7.
  - An address near 2^64 wraps to 0 in subsequent chunks.
- Mid-operation reset aborts any split immediately. No partial chunk is emitted after reset release.

Optional Feature:
NVDLA_BPT_SPLIT_STAT_EN:
- Defined: adds output ports stat_req_cnt[31:0] and stat_chunk_cnt[31:0].
  - stat_req_cnt counts accepted requests; stat_chunk_cnt counts consumed chunks (out_vld && out_rdy).
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Shared package nv_nvdla_mcif_bpt_pkg holds:
  - ADDR_W, SIZE_W, BOUND_ATOMS, LEN_W, ATOM_BYTES=32;
  - in_pd and out_pd field offset constants;
  - the state enum {IDLE, SPLIT}.
- One combinational sub-module, nv_nvdla_mcif_bpt_chunk_calc, takes cur_addr and rem and produces n, len, last and next_addr.

Test Plan:
- addr=0x1000, size=0 -> one chunk: addr 0x1000, len=0, first=1, last=1; split_idle returns to 1.
- addr=0x10E0, size=9 (10 atoms) -> three chunks:
  - 0x10E0 len=0 first;
  - 0x1100 len=7;
  - 0x1200 len=0 last.
- addr=0x2000, size=15, out_rdy toggling 1/0 each cycle -> chunks 0x2000 len=7 and 0x2100 len=7 last, each held stable during stalls.
- Back-to-back requests, size=0, out_rdy=1 -> one chunk per cycle with no bubble; in_rdy stays 1.
- addr=0xFFFFFFFFFFFFFFE0, size=1 -> chunks 0xFFFFFFFFFFFFFFE0 len=0 first, then 0x0 len=0 last.
- Assert reset mid-split after chunk 1 of a 10-atom request -> out_vld=0 and in_rdy=1 immediately; no further chunks. With NVDLA_BPT_SPLIT_STAT_EN, both counters read 0.

Source files
------------

// File: rtl/nv_nvdla_mcif_bpt_pkg.sv
// Shared constants, field offsets and state encoding for the BPT splitter.
// Payloads: in_pd {size,addr}, out_pd {last,first,len,addr}.
package nv_nvdla_mcif_bpt_pkg;

  localparam int ADDR_W      = 64;
  localparam int SIZE_W      = 15;
  localparam int BOUND_ATOMS = 8;
  localparam int LEN_W       = 3;
  localparam int ATOM_BYTES  = 32;
  localparam int ATOM_SH     = 5;
  localparam int REM_W       = SIZE_W + 1;
  localparam int N_W         = LEN_W + 1;

  localparam int IN_ADDR_LSB = 0;
  localparam int IN_SIZE_LSB = ADDR_W;
  localparam int IN_PD_W     = ADDR_W + SIZE_W;

  localparam int OUT_ADDR_LSB = 0;
  localparam int OUT_LEN_LSB  = ADDR_W;
  localparam int OUT_FIRST    = ADDR_W + LEN_W;
  localparam int OUT_LAST     = ADDR_W + LEN_W + 1;
  localparam int OUT_PD_W     = ADDR_W + LEN_W + 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } bpt_state_e;

endpackage

// File: rtl/nv_nvdla_mcif_bpt_chunk_calc.sv
// Combinational chunk sizing: clips the remaining atoms at the next 256B line.
// In: cur_addr, rem. Out: n (atoms), len (n-1), last, next_addr.
module nv_nvdla_mcif_bpt_chunk_calc
  import nv_nvdla_mcif_bpt_pkg::*;
(
  input  logic [ADDR_W-1:0] cur_addr,
  input  logic [REM_W-1:0]  rem,
  output logic [N_W-1:0]    n,
  output logic [LEN_W-1:0]  len,
  output logic              last,
  output logic [ADDR_W-1:0] next_addr
);

  logic [N_W-1:0] room;

  always_comb begin
    // atoms left before the address crosses into the next window
    room = N_W'(BOUND_ATOMS)
         - {1'b0, cur_addr[ATOM_SH+LEN_W-1:ATOM_SH]};
    if (rem < REM_W'(room)) n = rem[N_W-1:0];
    else                    n = room;
    len       = LEN_W'(n - N_W'(1));
    last      = (rem == REM_W'(n));
    next_addr = cur_addr + (ADDR_W'(n) << ATOM_SH);
  end

endmodule

// File: rtl/nv_nvdla_mcif_read_ig_bpt_split.sv
// Splits DMA read requests into chunks that never cross a 256B boundary.
// Ports: in_pd/in_vld/in_rdy, out_pd/out_vld/out_rdy, split_idle; stat_* with NVDLA_BPT_SPLIT_STAT_EN.
module nv_nvdla_mcif_read_ig_bpt_split
  import nv_nvdla_mcif_bpt_pkg::*;
(
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic [IN_PD_W-1:0]  in_pd,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic [OUT_PD_W-1:0] out_pd,
  output logic                out_vld,
  input  logic                out_rdy,
`ifdef NVDLA_BPT_SPLIT_STAT_EN
  output logic [31:0]         stat_req_cnt,
  output logic [31:0]         stat_chunk_cnt,
`endif
  output logic                split_idle
);

  bpt_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic                out_vld_q, out_vld_d;
  logic [OUT_PD_W-1:0] out_pd_q, out_pd_d;

  logic [ADDR_W-1:0]   in_addr, calc_addr, next_addr;
  logic [REM_W-1:0]    in_rem, calc_rem;
  logic [N_W-1:0]      n;
  logic [LEN_W-1:0]    len;
  logic                last, out_load, in_acc, src_vld, first;

  // low atom-offset bits are dropped on entry
  assign in_addr = in_pd[IN_ADDR_LSB +: ADDR_W]
                 & ~ADDR_W'(ATOM_BYTES - 1);
  assign in_rem  = REM_W'(in_pd[IN_SIZE_LSB +: SIZE_W]) + REM_W'(1);

  assign out_load = !out_vld_q || out_rdy;
  // accepting while the last chunk drains keeps requests back to back
  assign in_rdy   = (state_q == IDLE) && out_load;
  assign in_acc   = in_vld && in_rdy;
  assign first    = (state_q == IDLE);
  assign src_vld  = in_acc || (state_q == SPLIT);
  assign calc_addr = first ? in_addr : cur_addr_q;
  assign calc_rem  = first ? in_rem  : rem_q;

  nv_nvdla_mcif_bpt_chunk_calc u_calc (
    .cur_addr  (calc_addr),
    .rem       (calc_rem),
    .n         (n),
    .len       (len),
    .last      (last),
    .next_addr (next_addr)
  );

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    out_vld_d  = out_vld_q;
    out_pd_d   = out_pd_q;
    if (out_load) begin
      out_vld_d = src_vld;
      if (src_vld) begin
        out_pd_d   = {last, first, len, calc_addr};
        cur_addr_d = next_addr;
        rem_d      = calc_rem - REM_W'(n);
        state_d    = last ? IDLE : SPLIT;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      out_vld_q  <= 1'b0;
      out_pd_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      out_vld_q  <= out_vld_d;
      out_pd_q   <= out_pd_d;
    end
  end

  assign out_vld    = out_vld_q;
  assign out_pd     = out_pd_q;
  assign split_idle = (state_q == IDLE) && !out_vld_q;

`ifdef NVDLA_BPT_SPLIT_STAT_EN
  logic [31:0] req_cnt_q, req_cnt_d;
  logic [31:0] chunk_cnt_q, chunk_cnt_d;

  always_comb begin
    req_cnt_d   = req_cnt_q;
    chunk_cnt_d = chunk_cnt_q;
    if (in_acc && !(&req_cnt_q))
      req_cnt_d = req_cnt_q + 32'd1;
    if (out_vld_q && out_rdy && !(&chunk_cnt_q))
      chunk_cnt_d = chunk_cnt_q + 32'd1;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      req_cnt_q   <= '0;
      chunk_cnt_q <= '0;
    end else begin
      req_cnt_q   <= req_cnt_d;
      chunk_cnt_q <= chunk_cnt_d;
    end
  end

  assign stat_req_cnt   = req_cnt_q;
  assign stat_chunk_cnt = chunk_cnt_q;
`endif

endmodule

// File: tb/tb_nv_nvdla_mcif_read_ig_bpt_split.sv
// Directed bench for the BPT splitter with hand-computed chunk lists.
// Collects consumed chunks at negedge and compares against expected tables.
module tb_nv_nvdla_mcif_read_ig_bpt_split;

  logic        clk;
  logic        rstn;
  logic [78:0] in_pd;
  logic        in_vld;
  logic        in_rdy;
  logic [68:0] out_pd;
  logic        out_vld;
  logic        out_rdy;
  logic        split_idle;
`ifdef NVDLA_BPT_SPLIT_STAT_EN
  logic [31:0] stat_req_cnt;
  logic [31:0] stat_chunk_cnt;
`endif

  int n_chk;
  int n_err;
  int cyc;
  logic [68:0] got_q[$];
  int          got_cyc[$];
  logic [68:0] exp_q[$];
  logic [68:0] prev_pd;
  logic        stall;
  int          k;

  nv_nvdla_mcif_read_ig_bpt_split dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .in_pd           (in_pd),
    .in_vld          (in_vld),
    .in_rdy          (in_rdy),
    .out_pd          (out_pd),
    .out_vld         (out_vld),
    .out_rdy         (out_rdy),
`ifdef NVDLA_BPT_SPLIT_STAT_EN
    .stat_req_cnt    (stat_req_cnt),
    .stat_chunk_cnt  (stat_chunk_cnt),
`endif
    .split_idle      (split_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rstn && out_vld && out_rdy) begin
      got_q.push_back(out_pd);
      got_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [68:0] ck(input logic l, input logic f,
                                     input logic [2:0] len,
                                     input logic [63:0] a);
    return {l, f, len, a};
  endfunction

  task automatic send(input logic [63:0] a, input logic [14:0] s);
    int t;
    @(posedge clk); #1;
    in_pd  = {s, a};
    in_vld = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("accept timeout", 0, 1);
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!split_idle && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " idle"}, split_idle, 1);
  endtask

  task automatic chk_q(input string tag);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size())
        chk($sformatf("%s chunk%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    n_chk   = 0;
    n_err   = 0;
    cyc     = 0;
    rstn    = 1'b0;
    in_vld  = 1'b0;
    in_pd   = '0;
    out_rdy = 1'b1;
    prev_pd = '0;
    stall   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst out_vld", out_vld, 0);
    chk("rst in_rdy", in_rdy, 1);
    chk("rst idle", split_idle, 1);
    rstn = 1'b1;

    // single atom, low offset bits must be dropped
    send(64'h1007, 15'd0);
    wait_idle("t1");
    exp_q.push_back(ck(1, 1, 0, 64'h1000));
    chk_q("t1");

    // 10 atoms straddling two boundaries
    send(64'h10E0, 15'd9);
    wait_idle("t2");
    exp_q.push_back(ck(0, 1, 0, 64'h10E0));
    exp_q.push_back(ck(0, 0, 7, 64'h1100));
    exp_q.push_back(ck(1, 0, 0, 64'h1200));
    chk_q("t2");

    // toggling out_rdy, output must hold during stalls
    fork
      send(64'h2000, 15'd15);
      begin
        stall = 1'b0;
        for (int i = 0; i < 14; i++) begin
          @(posedge clk); #1;
          out_rdy = (i % 2) != 0;
          @(negedge clk);
          if (stall) chk("t3 hold", {out_vld, out_pd}, {1'b1, prev_pd});
          stall   = out_vld && !out_rdy;
          prev_pd = out_pd;
        end
      end
    join
    out_rdy = 1'b1;
    wait_idle("t3");
    exp_q.push_back(ck(0, 1, 7, 64'h2000));
    exp_q.push_back(ck(1, 0, 7, 64'h2100));
    chk_q("t3");

    // back-to-back single-atom requests, no bubbles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_vld = 1'b1;
      in_pd  = {15'd0, 64'h3000 + 64'(i * 32)};
      @(negedge clk);
      chk($sformatf("t4 in_rdy%0d", i), in_rdy, 1);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_idle("t4");
    if (got_cyc.size() == 3) begin
      chk("t4 gap01", got_cyc[1] - got_cyc[0], 1);
      chk("t4 gap12", got_cyc[2] - got_cyc[1], 1);
    end
    exp_q.push_back(ck(1, 1, 0, 64'h3000));
    exp_q.push_back(ck(1, 1, 0, 64'h3020));
    exp_q.push_back(ck(1, 1, 0, 64'h3040));
    chk_q("t4");

    // address wrap at the top of the space
    send(64'hFFFF_FFFF_FFFF_FFE0, 15'd1);
    wait_idle("t5");
    exp_q.push_back(ck(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFE0));
    exp_q.push_back(ck(1, 0, 0, 64'h0));
    chk_q("t5");

    // reset after the first chunk of a 10-atom split
    send(64'h10E0, 15'd9);
    k = 0;
    while (got_q.size() < 1 && k < 50) begin
      @(negedge clk); #1;
      k++;
    end
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t6 rst out_vld", out_vld, 0);
    chk("t6 rst in_rdy", in_rdy, 1);
    chk("t6 rst idle", split_idle, 1);
`ifdef NVDLA_BPT_SPLIT_STAT_EN
    chk("t6 req_cnt", stat_req_cnt, 0);
    chk("t6 chunk_cnt", stat_chunk_cnt, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    chk("t6 post out_vld", out_vld, 0);
    exp_q.push_back(ck(0, 1, 0, 64'h10E0));
    chk_q("t6");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
